// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - two-master IO bus arbiter with burst-limited fairness
// and an in-order read-return tag pipeline.
module io_bus_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m1_req,
  input  logic                  m0_write,
  input  logic                  m1_write,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  IO_write,
  output logic [ADDR_WIDTH-1:0] IO_address,
  output logic [DATA_WIDTH-1:0] IO_data_in,
  input  logic [DATA_WIDTH-1:0] IO_data_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  logic [1:0]              state;
  logic [3:0]              burst_cnt;
  logic                    last_m1;
  logic                    pick_m1;
  logic                    read_issue;
  logic                    tag_out;
  logic [READ_LATENCY-1:0] tag_valid;
  logic [READ_LATENCY-1:0] tag_owner;
  logic [DATA_WIDTH-1:0]   rdata0_q;
  logic [DATA_WIDTH-1:0]   rdata1_q;
  logic [3:0]              cnt_next;

  // Only a tie consults state/counter; a lone requester always wins.
  always_comb begin
    pick_m1 = 1'b0;
    if (m0_req && m1_req) begin
      case (state)
        OWN0:    pick_m1 = (burst_cnt >= MAX_CNT);
        OWN1:    pick_m1 = (burst_cnt < MAX_CNT);
        default: pick_m1 = !last_m1;
      endcase
    end else begin
      pick_m1 = m1_req;
    end
  end

  assign m0_gnt = !rst && m0_req && !pick_m1;
  assign m1_gnt = !rst && m1_req && pick_m1;

  always_comb begin
    IO_write   = 1'b0;
    IO_address = '0;
    IO_data_in = '0;
    read_issue = 1'b0;
    if (m0_gnt) begin
      IO_write   = m0_write;
      IO_address = m0_address;
      IO_data_in = m0_wdata;
      read_issue = !m0_write;
    end else if (m1_gnt) begin
      IO_write   = m1_write;
      IO_address = m1_address;
      IO_data_in = m1_wdata;
      read_issue = !m1_write;
    end
  end

  assign cnt_next  = (burst_cnt >= MAX_CNT) ? MAX_CNT : burst_cnt + 4'd1;
  assign tag_out   = tag_valid[READ_LATENCY-1] && !rst;
  assign m0_rvalid = tag_out && !tag_owner[READ_LATENCY-1];
  assign m1_rvalid = tag_out && tag_owner[READ_LATENCY-1];
  assign m0_rdata  = m0_rvalid ? IO_data_out : rdata0_q;
  assign m1_rdata  = m1_rvalid ? IO_data_out : rdata1_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= 4'd0;
      last_m1   <= 1'b1;
      tag_valid <= '0;
      tag_owner <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      if (m0_gnt) begin
        state     <= OWN0;
        burst_cnt <= (state == OWN0) ? cnt_next : 4'd1;
        last_m1   <= 1'b0;
      end else if (m1_gnt) begin
        state     <= OWN1;
        burst_cnt <= (state == OWN1) ? cnt_next : 4'd1;
        last_m1   <= 1'b1;
      end else begin
        state <= IDLE;
      end
      // Tags move one stage per cycle, so reads return strictly in issue order.
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_owner[i] <= tag_owner[i-1];
      end
      tag_valid[0] <= read_issue;
      tag_owner[0] <= m1_gnt;
      if (m0_rvalid) rdata0_q <= IO_data_out;
      if (m1_rvalid) rdata1_q <= IO_data_out;
    end
  end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, IO address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, IO data width.
REQ-003 SHALL have parameter READ_LATENCY, default 1, number of cycles from address to valid IO_data_out (legal 1..4).
REQ-004 SHALL have parameter MAX_BURST, default 4, maximum consecutive transfers per owner while the other requester waits (legal 1..15).
REQ-005 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have ports m0_req, m1_req  input  1  transfer request (m0 = processor, m1 = DMA/secondary master).
REQ-008 SHALL have ports m0_write, m1_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have ports m0_address, m1_address  input  ADDR_WIDTH  target IO address.
REQ-010 SHALL have ports m0_wdata, m1_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have ports m0_gnt, m1_gnt  output  1  combinational grant; a transfer completes on the rising edge where req and gnt are both 1.
REQ-012 SHALL have ports m0_rvalid, m1_rvalid  output  1  one-cycle pulse qualifying read data.
REQ-013 SHALL have ports m0_rdata, m1_rdata  output  DATA_WIDTH  read data.
REQ-014 SHALL have port IO_write  output  1  memory write strobe.
REQ-015 SHALL have port IO_address  output  ADDR_WIDTH  memory address.
REQ-016 SHALL have port IO_data_in  output  DATA_WIDTH  memory write data.
REQ-017 SHALL have port IO_data_out  input  DATA_WIDTH  memory read data.

Function
REQ-018 SHALL grant at most one requester per cycle; m0_gnt and m1_gnt are never both 1.
REQ-019 SHALL assert gnt only for a requester whose req is 1 in the same cycle.
REQ-020 SHALL drive IO_address/IO_data_in from the granted requester, with IO_write = write & req & gnt; with no grant, IO_write = 0 and IO_address = IO_data_in = 0.
REQ-021 SHALL track a registered state with values IDLE, OWN0 and OWN1, plus a burst counter. Each cycle it SHALL move to OWNx if requester x transferred, else to IDLE.
REQ-022 Counter rules: reset to 1 on an owner change or on a transfer from IDLE; +1 on each consecutive transfer by the same owner; saturate at MAX_BURST.
REQ-023 SHALL decide grants as follows, when only one requester asserts req: that requester is granted, regardless of state or counter.
REQ-024 SHALL decide grants as follows, when both requesters assert req in IDLE: the grant goes to the requester not granted last; after reset, m0 wins.
REQ-025 SHALL decide grants as follows, when both requesters assert req in OWNx: grant stays with x while counter < MAX_BURST; at counter == MAX_BURST, grant moves to the other requester.
REQ-026 For each read transfer, SHALL pipeline a tag (valid, owner) of depth READ_LATENCY. When the tag emerges, it SHALL pulse rvalid of the tagged owner for exactly one cycle, with rdata = IO_data_out in that cycle.
REQ-027 rdata SHALL hold its last value when rvalid is 0; the non-tagged owner's rvalid SHALL be 0.
REQ-028 Writes SHALL produce no rvalid. Back-to-back reads, including reads alternating between owners, SHALL return in issue order, one per cycle.
REQ-029 No transfer SHALL be lost or duplicated when req drops in the same cycle the grant switches.

Reset
REQ-030 While rst = 1 at a rising edge, SHALL set state to IDLE, counter to 0, last-granted to m1 (so m0 wins the first tie), all read tags invalid, and m0_rdata = m1_rdata = 0.
REQ-031 During reset, gnt, IO_write and rvalid SHALL be 0. Reads in flight are discarded: no rvalid is produced for them after reset releases.

Verification
REQ-032 Bench SHALL cover: rst held 3 cycles with both req = 1 -> gnt 0/0, IO_write 0, rvalid 0/0; first cycle after release, m0_gnt = 1.
REQ-033 Bench SHALL cover: m0 alone writes 0xBEEF to 0x123 -> same cycle m0_gnt = 1, IO_write = 1, IO_address = 0x123, IO_data_in = 0xBEEF; no rvalid.
REQ-034 Bench SHALL cover: m1 alone reads 0x010, memory model returns 0x5A5A, READ_LATENCY = 1 -> next cycle m1_rvalid = 1, m1_rdata = 0x5A5A, m0_rvalid = 0.
REQ-035 Bench SHALL cover: both req held constantly, MAX_BURST = 4 -> grant sequence 0,0,0,0,1,1,1,1,0.
REQ-036 Bench SHALL cover: alternating reads m0@0x001, m1@0x002, m0@0x003, READ_LATENCY = 3 -> rvalid pulses m0,m1,m0 on consecutive cycles, 3 cycles after each issue, with matching data.
REQ-037 Bench SHALL cover: rst asserted 1 cycle after an m0 read issue with READ_LATENCY = 2 -> m0_rvalid never asserts for that read.
